// File: rtl/regfile_dump_reader.sv
// Streams every architectural register out over a valid/ready port after a rising halt edge.
// Build option: define DUMP_R0_EN to include R0 in the dump (otherwise R1..R15 only).
module regfile_dump_reader #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  output logic        rf_re,
  output logic [3:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output logic        dump_vld,
  input  logic        dump_rdy,
  output logic [3:0]  dump_idx,
  output logic [15:0] dump_data,
  output logic        dump_busy,
  output logic        dump_done
);

`ifdef DUMP_R0_EN
  localparam logic [3:0] START_IDX = 4'd0;
`else
  localparam logic [3:0] START_IDX = 4'd1;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  dump_idx_q, dump_idx_d;
  logic [15:0] dump_data_q, dump_data_d;
  logic        dump_vld_q, dump_vld_d;
  logic        hlt_ff_q;
  logic        start;

  assign start = hlt & ~hlt_ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      dump_idx_q  <= 4'd0;
      dump_data_q <= 16'd0;
      dump_vld_q  <= 1'b0;
      hlt_ff_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      dump_vld_q  <= dump_vld_d;
      hlt_ff_q    <= hlt;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    dump_vld_d  = dump_vld_q;
    rf_re       = 1'b0;
    rf_raddr    = 4'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = START_IDX;
          state_d = READ;
        end
      end
      // Register file samples the address on the negedge; data is ready by the next posedge.
      READ: begin
        rf_re       = 1'b1;
        rf_raddr    = idx_q;
        dump_data_d = rf_rdata;
        dump_idx_d  = idx_q;
        dump_vld_d  = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (dump_vld_q && dump_rdy) begin
          dump_vld_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        if (!hlt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_vld  = dump_vld_q;
  assign dump_idx  = dump_idx_q;
  assign dump_data = dump_data_q;
  assign dump_busy = (state_q == READ) || (state_q == PRESENT);
  assign dump_done = (state_q == DONE);

endmodule
